// File: rtl/aurora_frame_gen_if.sv
// aurora_frame_gen_if: AXI4-Stream TX bundle between the frame generator and
// the Aurora core user port (big-endian bit numbering, bit 0 = MSB).
interface aurora_frame_gen_if;
  logic [0:31] tx_data;
  logic        tx_tvalid;
  logic        tx_tready;
  logic [0:3]  tx_tkeep;
  logic        tx_tlast;

  modport master (
    output tx_data,
    output tx_tvalid,
    output tx_tkeep,
    output tx_tlast,
    input  tx_tready
  );

  modport slave (
    input  tx_data,
    input  tx_tvalid,
    input  tx_tkeep,
    input  tx_tlast,
    output tx_tready
  );
endinterface

// File: rtl/aurora_frame_gen.sv
// aurora_frame_gen: counting-payload AXI4-Stream frame source for Aurora TX.
// Define AURORA_FRAME_GEN_HDR_EN to prefix each frame with a header beat.
module aurora_frame_gen #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned IDLE_GAP  = 4,
  parameter logic [3:0]  LAST_KEEP = 4'b1111,
  parameter logic [31:0] SEED      = 32'h00000000
) (
  input  logic                      io_clk,
  input  logic                      RESET_N,
  input  logic                      enable,
  input  logic                      channel_up,
  aurora_frame_gen_if.master        tx,
  output logic [15:0]               frame_count,
  output logic                      busy
);

  localparam logic [15:0] LAST_BEAT = 16'(FRAME_LEN - 1);
  localparam logic [15:0] GAP_LAST  = 16'(IDLE_GAP - 1);

`ifdef AURORA_FRAME_GEN_HDR_EN
  typedef enum logic [1:0] {
    S_IDLE, S_HDR, S_DATA, S_GAP
  } state_t;
  localparam state_t S_START = S_HDR;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_DATA, S_GAP
  } state_t;
  localparam state_t S_START = S_DATA;
`endif

  logic [1:0]  rst_sync_q;
  logic        rst_n;
  state_t      state_q, state_d;
  logic [15:0] beat_q, beat_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] frame_q, frame_d;
  logic [31:0] word_q, word_d;
  logic        start;
  logic        is_last;
  logic        valid;
  logic [31:0] data;
  logic [3:0]  keep;
  logic        last;

  // Assert asynchronously, release two edges later.
  always_ff @(posedge io_clk or negedge RESET_N) begin
    if (!RESET_N) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  always_ff @(posedge io_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      gap_q   <= '0;
      frame_q <= '0;
      word_q  <= SEED;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      frame_q <= frame_d;
      word_q  <= word_d;
    end
  end

  assign start   = enable && channel_up;
  assign is_last = (beat_q == LAST_BEAT);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    frame_d = frame_q;
    word_d  = word_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_START;
      end
`ifdef AURORA_FRAME_GEN_HDR_EN
      S_HDR: begin
        if (!channel_up) begin
          state_d = S_IDLE;
        end else if (tx.tx_tready) begin
          state_d = S_DATA;
          beat_d  = '0;
        end
      end
`endif
      // A link drop wins over a same-cycle handshake: nothing is counted.
      S_DATA: begin
        if (!channel_up) begin
          state_d = S_IDLE;
          beat_d  = '0;
        end else if (tx.tx_tready) begin
          word_d = word_q + 32'd1;
          if (is_last) begin
            beat_d  = '0;
            gap_d   = '0;
            frame_d = frame_q + 16'd1;
            if (IDLE_GAP == 0)
              state_d = start ? S_START : S_IDLE;
            else
              state_d = S_GAP;
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
      end
      // Final gap cycle already acts as IDLE so the gap is exact.
      S_GAP: begin
        if (gap_q == GAP_LAST)
          state_d = start ? S_START : S_IDLE;
        else
          gap_d = gap_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid = 1'b0;
    data  = '0;
    keep  = '0;
    last  = 1'b0;
    unique case (state_q)
`ifdef AURORA_FRAME_GEN_HDR_EN
      S_HDR: begin
        valid = 1'b1;
        data  = {16'hA5A5, frame_q};
        keep  = 4'hF;
      end
`endif
      S_DATA: begin
        valid = 1'b1;
        data  = word_q;
        last  = is_last;
        keep  = is_last ? LAST_KEEP : 4'hF;
      end
      default: ;
    endcase
  end

  assign tx.tx_tvalid = valid;
  assign tx.tx_data   = data;
  assign tx.tx_tkeep  = keep;
  assign tx.tx_tlast  = last;
  assign frame_count  = frame_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_aurora_frame_gen.sv
// tb_aurora_frame_gen: directed checks of frame shape, stalls, gaps, link
// drop and counter wrap across three differently configured generators.
module tb_aurora_frame_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en  [3];
  logic        cu  [3];
  logic        rdy [3];
  logic [31:0] dat [3];
  logic        vld [3];
  logic [3:0]  kp  [3];
  logic        lst [3];
  logic [15:0] fc  [3];
  logic        bsy [3];

  int n_run  = 0;
  int n_fail = 0;

  aurora_frame_gen_if if0 ();
  aurora_frame_gen_if if1 ();
  aurora_frame_gen_if if2 ();

  assign if0.tx_tready = rdy[0];
  assign if1.tx_tready = rdy[1];
  assign if2.tx_tready = rdy[2];
  assign dat[0] = if0.tx_data;
  assign dat[1] = if1.tx_data;
  assign dat[2] = if2.tx_data;
  assign vld[0] = if0.tx_tvalid;
  assign vld[1] = if1.tx_tvalid;
  assign vld[2] = if2.tx_tvalid;
  assign kp[0]  = if0.tx_tkeep;
  assign kp[1]  = if1.tx_tkeep;
  assign kp[2]  = if2.tx_tkeep;
  assign lst[0] = if0.tx_tlast;
  assign lst[1] = if1.tx_tlast;
  assign lst[2] = if2.tx_tlast;

  aurora_frame_gen #(
    .FRAME_LEN (4),
    .IDLE_GAP  (4),
    .LAST_KEEP (4'b0111),
    .SEED      (32'h0000_0000)
  ) dut0 (
    .io_clk      (clk),
    .RESET_N     (rst_n),
    .enable      (en[0]),
    .channel_up  (cu[0]),
    .tx          (if0.master),
    .frame_count (fc[0]),
    .busy        (bsy[0])
  );

  aurora_frame_gen #(
    .FRAME_LEN (4),
    .IDLE_GAP  (0),
    .LAST_KEEP (4'b0011),
    .SEED      (32'hFFFF_FFFE)
  ) dut1 (
    .io_clk      (clk),
    .RESET_N     (rst_n),
    .enable      (en[1]),
    .channel_up  (cu[1]),
    .tx          (if1.master),
    .frame_count (fc[1]),
    .busy        (bsy[1])
  );

  aurora_frame_gen #(
    .FRAME_LEN (1),
    .IDLE_GAP  (2),
    .LAST_KEEP (4'b1000),
    .SEED      (32'h0000_0100)
  ) dut2 (
    .io_clk      (clk),
    .RESET_N     (rst_n),
    .enable      (en[2]),
    .channel_up  (cu[2]),
    .tx          (if2.master),
    .frame_count (fc[2]),
    .busy        (bsy[2])
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int k, input string tag,
                      input logic [31:0] d,
                      input logic [3:0] kk,
                      input logic l);
    check({tag, " vld"},  32'(vld[k]), 32'd1);
    check({tag, " data"}, dat[k], d);
    check({tag, " keep"}, 32'(kp[k]), 32'(kk));
    check({tag, " last"}, 32'(lst[k]), 32'(l));
  endtask

  // Follows nf frames with tready=1, checking each beat and inter-frame gap.
  task automatic run_frames(input int k, input string tag, input int nf,
                            input int flen, input int exp_gap,
                            input logic [3:0] lk,
                            input logic [31:0] w_in,
                            output logic [31:0] w_out);
    logic [31:0] w;
    int bn;
    int frames;
    int low;
    bit counting;
    w = w_in;
    bn = 0;
    frames = 0;
    low = 0;
    counting = 0;
    for (int c = 0; c < 200 && frames < nf; c++) begin
      if (vld[k]) begin
        if (counting) begin
          check($sformatf("%s gap", tag), low, exp_gap);
          counting = 0;
        end
        beat(k, $sformatf("%s f%0d b%0d", tag, frames, bn), w,
             (bn == flen - 1) ? lk : 4'hF, bn == flen - 1);
        w = w + 32'd1;
        if (bn == flen - 1) begin
          bn = 0;
          frames++;
          counting = 1;
          low = 0;
        end else begin
          bn++;
        end
      end else if (counting) begin
        low++;
      end
      cyc();
    end
    check($sformatf("%s frames", tag), frames, nf);
    w_out = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] exp;
    int n;
    logic r;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      en[k]  = 1'b0;
      cu[k]  = 1'b1;
      rdy[k] = 1'b1;
    end
    #12;
    check("rst vld",   32'(vld[0]), 32'd0);
    check("rst data",  dat[0], 32'd0);
    check("rst keep",  32'(kp[0]), 32'd0);
    check("rst last",  32'(lst[0]), 32'd0);
    check("rst fc",    32'(fc[0]), 32'd0);
    check("rst busy",  32'(bsy[0]), 32'd0);
    check("rst data1", dat[1], 32'd0);
    check("rst fc2",   32'(fc[2]), 32'd0);

    @(negedge clk);
    en[0] = 1'b1;
    rst_n = 1'b1;
    cyc();
    check("sync edge1 vld", 32'(vld[0]), 32'd0);
    en[0] = 1'b0;
    cyc();
    check("sync edge2 vld", 32'(vld[0]), 32'd0);
    cyc();

`ifdef AURORA_FRAME_GEN_HDR_EN
    en[2] = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 10 && !vld[2]; c++) cyc();
      beat(2, $sformatf("hdr f%0d", f),
           {16'hA5A5, 16'(f)}, 4'hF, 1'b0);
      cyc();
      beat(2, $sformatf("hdr pay f%0d", f),
           32'h100 + 32'(f), 4'b1000, 1'b1);
      cyc();
    end
    en[2] = 1'b0;
    for (int c = 0; c < 6; c++) cyc();
    check("hdr fc", 32'(fc[2]), 32'd3);
    check("hdr busy", 32'(bsy[2]), 32'd0);
`else
    en[0] = 1'b1;
    cyc();
    en[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(0, $sformatf("pulse b%0d", i), 32'(i),
           (i == 3) ? 4'b0111 : 4'hF, i == 3);
      cyc();
    end
    check("pulse gap vld", 32'(vld[0]), 32'd0);
    check("pulse fc", 32'(fc[0]), 32'd1);
    check("pulse busy gap", 32'(bsy[0]), 32'd1);
    for (int c = 0; c < 5; c++) cyc();
    check("pulse busy idle", 32'(bsy[0]), 32'd0);

    en[0] = 1'b1;
    cyc();
    en[0] = 1'b0;
    exp = 32'd4;
    n = 0;
    r = 1'b0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      rdy[0] = r;
      beat(0, $sformatf("stall c%0d", c), exp,
           (exp == 32'd7) ? 4'b0111 : 4'hF, exp == 32'd7);
      if (r) begin
        exp = exp + 32'd1;
        n++;
      end
      r = ~r;
      cyc();
    end
    rdy[0] = 1'b1;
    check("stall beats", n, 4);
    check("stall end vld", 32'(vld[0]), 32'd0);
    check("stall fc", 32'(fc[0]), 32'd2);
    for (int c = 0; c < 5; c++) cyc();

    en[0] = 1'b1;
    run_frames(0, "gap4", 3, 4, 4, 4'b0111, 32'd8, w0);
    en[0] = 1'b0;
    check("gap4 word", w0, 32'd20);
    check("gap4 fc", 32'(fc[0]), 32'd5);
    for (int c = 0; c < 5; c++) cyc();

    en[0] = 1'b1;
    cyc();
    en[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(0, $sformatf("drop b%0d", i), w0 + 32'(i), 4'hF, 1'b0);
      cyc();
    end
    cu[0] = 1'b0;
    cyc();
    check("drop vld", 32'(vld[0]), 32'd0);
    check("drop fc", 32'(fc[0]), 32'd5);
    check("drop busy", 32'(bsy[0]), 32'd0);
    cu[0] = 1'b1;
    en[0] = 1'b1;
    cyc();
    en[0] = 1'b0;
    run_frames(0, "resume", 1, 4, 0, 4'b0111, 32'd23, w0);
    check("resume fc", 32'(fc[0]), 32'd6);

    en[1] = 1'b1;
    cyc();
    en[1] = 1'b0;
    run_frames(1, "wrap", 1, 4, 0, 4'b0011, 32'hFFFF_FFFE, w1);
    check("wrap word", w1, 32'd2);
    check("wrap fc", 32'(fc[1]), 32'd1);
    cyc();
    cyc();
    en[1] = 1'b1;
    run_frames(1, "gap0", 3, 4, 0, 4'b0011, w1, w1);
    en[1] = 1'b0;
    run_frames(1, "gap0 tail", 1, 4, 0, 4'b0011, w1, w1);
    cyc();
    check("gap0 fc", 32'(fc[1]), 32'd5);
    check("gap0 idle vld", 32'(vld[1]), 32'd0);

    en[2] = 1'b1;
    cyc();
    en[2] = 1'b0;
    run_frames(2, "len1", 1, 1, 0, 4'b1000, 32'h100, w2);
    check("len1 fc", 32'(fc[2]), 32'd1);
    check("len1 vld", 32'(vld[2]), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/aurora_frame_gen.md
AURORA_FRAME_GEN -- requirements
Module: aurora_frame_gen

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 16, meaning payload beats per frame (legal range 1..65535).
REQ-002 The block SHALL have parameter IDLE_GAP, default 4, meaning tvalid-low cycles between frames (0 = back-to-back).
REQ-003 The block SHALL have parameter LAST_KEEP, default 4'b1111, meaning tx_tkeep value on the tlast beat.
REQ-004 The block SHALL have parameter SEED, default 32'h00000000, meaning the first payload word after reset.
REQ-005 The block SHALL have port io_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port enable, input, 1 bit: frame generation request.
REQ-008 The block SHALL have port channel_up, input, 1 bit: Aurora CHANNEL_UP status.
REQ-009 The block SHALL have port tx_data, output, [0:31]: AXI4-Stream data, bit 0 = MSB.
REQ-010 The block SHALL have port tx_tvalid, output, 1 bit: beat valid.
REQ-011 The block SHALL have port tx_tready, input, 1 bit: sink ready.
REQ-012 The block SHALL have port tx_tkeep, output, [0:3]: byte enables, bit 0 = byte [0:7].
REQ-013 The block SHALL have port tx_tlast, output, 1 bit: last beat of frame.
REQ-014 The block SHALL have port frame_count, output, [15:0]: completed frames.
REQ-015 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, HDR (only when HDR_EN is defined), DATA and GAP.
REQ-017 IDLE->HDR/DATA SHALL occur on a cycle where enable=1 and channel_up=1; tx_tvalid SHALL rise on the next cycle.
REQ-018 A beat SHALL be accepted only on a cycle where tx_tvalid=1 and tx_tready=1.
REQ-019 While tx_tvalid=1 and tx_tready=0, tx_data, tx_tkeep and tx_tlast SHALL hold stable.
REQ-020 The payload word SHALL come from a 32-bit counter that starts at SEED, increments by 1 per accepted payload beat, wraps from 32'hFFFFFFFF to 0, and persists across frames.
REQ-021 tx_tkeep SHALL be 4'b1111 on non-last beats and LAST_KEEP on the tlast beat.
REQ-022 tx_tlast SHALL be 1 only on payload beat FRAME_LEN; with FRAME_LEN=1 the single payload beat SHALL carry tlast.
REQ-023 After the tlast beat is accepted, frame_count SHALL increment by 1, wrapping from 16'hFFFF to 0, and the FSM SHALL enter GAP.
REQ-024 GAP SHALL hold tx_tvalid=0 for exactly IDLE_GAP cycles, then behave as IDLE; with IDLE_GAP=0, GAP SHALL be skipped and the next frame's first beat SHALL be valid on the cycle after the tlast acceptance if enable=1 and channel_up=1.
REQ-025 If enable falls mid-frame, the current frame SHALL complete normally.
REQ-026 If channel_up falls mid-frame, tx_tvalid SHALL drop on the next cycle, the FSM SHALL go to IDLE, frame_count SHALL NOT increment, and the data counter SHALL keep its value.
REQ-027 Latency SHALL be 1 cycle from a start condition to the first valid beat, and 0 bubbles between beats while tx_tready=1.

Reset
REQ-028 On RESET_N=0 the block SHALL asynchronously set state=IDLE, tx_tvalid=0, tx_tlast=0, tx_tkeep=0, tx_data=0, frame_count=0, busy=0, and data counter=SEED.
REQ-029 Reset deassertion SHALL be synchronised to io_clk, and the first start SHALL be possible no earlier than the second rising edge after RESET_N rises.
REQ-030 Reset asserted mid-frame SHALL abandon the frame without counting it.

Configuration
REQ-031 Macro AURORA_FRAME_GEN_HDR_EN, when defined, SHALL insert one HDR beat before the payload, with tx_data={16'hA5A5, frame_count}, tkeep=4'b1111 and tlast=0; the HDR beat SHALL NOT advance the data counter.
REQ-032 When AURORA_FRAME_GEN_HDR_EN is undefined, the HDR state and its logic SHALL be absent and frames SHALL be payload-only.

Verification
REQ-033 The bench SHALL cover: FRAME_LEN=4, tready=1, enable pulse -> beats 0,1,2,3 with tlast on 3, tkeep F,F,F,LAST_KEEP, and frame_count=1.
REQ-034 The bench SHALL cover: tready toggled 1/0 each cycle mid-frame -> data held stable while stalled and no beat lost or duplicated.
REQ-035 The bench SHALL cover: enable held high, IDLE_GAP=4 -> exactly 4 tvalid-low cycles between frames, and 8'd0 bubbles with IDLE_GAP=0.
REQ-036 The bench SHALL cover: channel_up dropped after beat 2 -> tvalid=0 next cycle, frame_count unchanged, and the next frame resumes at word 3.
REQ-037 The bench SHALL cover: SEED=32'hFFFFFFFE, FRAME_LEN=4 -> words FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-038 The bench SHALL cover: HDR_EN defined, third frame -> first beat 32'hA5A50002, followed by the payload.
